// File: rtl/fp_sub_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fp_sub_stream_ctrl
//
// Valid/ready streaming wrapper around a fixed-latency, non-stallable
// floating-point subtractor pipeline (FP_subtractor_13ccs). Operand pairs are
// forwarded combinationally to the external pipe; a one-bit tag per pipe
// stage tracks which cycles carry a real issue. When a tagged slot leaves the
// pipe, the result is written unconditionally into a result FIFO.
//
// A credit counter sized to the FIFO depth throttles issue, so every
// in-flight result is guaranteed a FIFO slot. Downstream backpressure
// therefore never drops a result even though the pipe itself cannot stall.
//
// Ports
//   clock      in   1            single clock, rising edge
//   reset      in   1            asynchronous, active-high, clears all state
//   in_valid   in   1            operand pair valid
//   in_ready   out  1            a pair can be accepted this cycle
//   in_a       in   WIDTH        minuend
//   in_b       in   WIDTH        subtrahend
//   sub_a      out  WIDTH        to subtractor io_in_a (copy of in_a)
//   sub_b      out  WIDTH        to subtractor io_in_b (copy of in_b)
//   sub_s      in   WIDTH        from subtractor io_out_s
//   out_valid  out  1            out_s holds a valid difference
//   out_ready  in   1            consumer accepts out_s
//   out_s      out  WIDTH        difference a-b, FIFO head
//   occupancy  out  log2(D)+1    in-flight results + stored results
//
// Parameters
//   WIDTH    operand/result width
//   LATENCY  cycles from sub_a/sub_b to sub_s, >= 1
//   DEPTH    result FIFO entries, power of two, >= LATENCY and >= 2
// ---------------------------------------------------------------------------
module fp_sub_stream_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 13,
    parameter int DEPTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,

    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,
    input  logic [WIDTH-1:0]         sub_s,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_s,

    output logic [$clog2(DEPTH):0]   occupancy
);

    // Pointer index width and counter width (one extra bit).
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CREDITS_FULL = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    logic fire_in;
    logic fire_out;
    logic capture;
    logic fifo_empty;

    // The operands go straight to the pipe; the pipe samples them every
    // cycle, and only the tag decides whether the slot is a real issue.
    assign sub_a = in_a;
    assign sub_b = in_b;

    // in_ready depends on registers only, so there is no in_valid->in_ready
    // combinational path for the producer to close into a loop.
    assign in_ready = (credits_q != '0);
    assign fire_in  = in_valid & in_ready;

    // The oldest tag stage marks the cycle in which sub_s carries the result
    // of a real issue.
    assign capture = tag_q[LATENCY-1];

    // Extra pointer MSB: equal pointers mean empty, equal index with
    // differing MSB means full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign out_valid  = ~fifo_empty;
    assign fire_out   = out_valid & out_ready;
    assign out_s      = mem_q[rd_ptr_q[PW-1:0]];

    // Every credit not held represents a result either in the pipe or in
    // the FIFO.
    assign occupancy = CREDITS_FULL - credits_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        tag_d    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        credits_d = credits_q;

        // The tag pipe never stalls, mirroring the external subtractor.
        tag_d[0] = fire_in;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (capture) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (fire_out) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end

        // Issue consumes a credit, pop returns one; both together cancel.
        unique case ({fire_in, fire_out})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Clearing the tags discards results of pre-reset issues that
            // are still travelling through the external pipe.
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            credits_q <= CREDITS_FULL;
        end else begin
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            credits_q <= credits_d;
        end
    end

    // ------------------------------------------------------------------
    // Result storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is reset because out_s exposes the head entry
    // directly and must read as zero after reset; with only DEPTH words this
    // is a handful of flops, not a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (capture) begin
            // Written unconditionally: credits guarantee a free slot, and a
            // pop in the same cycle only frees the head, never this slot.
            mem_q[wr_ptr_q[PW-1:0]] <= sub_s;
        end
    end

endmodule
